// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALUOp classes,
// the per-stage control bundles and the bubble constant.
// Optional feature macro: CTRL_JUMP_EN (adds JAL/JALR/LUI/AUIPC decode).
package ctrl_pkg;

  localparam int CTRL_OPCODE_W = 7;
  localparam int CTRL_REG_W    = 5;
  localparam int CTRL_ALUOP_W  = 2;

  localparam logic [CTRL_OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD    = 2'b00;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT  = 2'b10;

  // Full bundle as decoded in ID and held in the ID/EX register
  typedef struct packed {
    logic                    valid;
    logic                    alusrc;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic                    branch;
    logic                    memread;
    logic                    memwrite;
    logic                    regwrite;
    logic                    memtoreg;
    logic                    illegal;
`ifdef CTRL_JUMP_EN
    logic                    jump;
    logic                    jalr;
`endif
    logic [CTRL_REG_W-1:0]   rd;
  } ctrl_t;

  // EX/MEM keeps only what the MEM and WB stages still need
  typedef struct packed {
    logic                  valid;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic                  memtoreg;
    logic [CTRL_REG_W-1:0] rd;
  } mem_t;

  // MEM/WB keeps only the write-back controls
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memtoreg;
    logic [CTRL_REG_W-1:0] rd;
  } wb_t;

  localparam ctrl_t BUBBLE = '0;

  function automatic mem_t to_mem(input ctrl_t c);
    mem_t m;
    m.valid    = c.valid;
    m.memread  = c.memread;
    m.memwrite = c.memwrite;
    m.regwrite = c.regwrite;
    m.memtoreg = c.memtoreg;
    m.rd       = c.rd;
    return m;
  endfunction

  function automatic wb_t to_wb(input mem_t m);
    wb_t w;
    w.valid    = m.valid;
    w.regwrite = m.regwrite;
    w.memtoreg = m.memtoreg;
    w.rd       = m.rd;
    return w;
  endfunction

endpackage

// File: rtl/pipelined_ctrl_unit_if.sv
// Bus between the control unit and the datapath: ID-stage instruction fields,
// pipeline control inputs and the per-stage control outputs.
// Optional feature macro: CTRL_JUMP_EN (adds ex_jump / ex_jalr).
interface pipelined_ctrl_unit_if #(
  parameter int OPCODE_W = 7,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rs1;
  logic [REG_W-1:0]    id_rs2;
  logic [REG_W-1:0]    id_rd;
  logic                freeze;
  logic                flush_ex;
  logic                hazard_stall;
  logic                ex_alusrc;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic                ex_branch;
  logic                ex_illegal;
  logic [REG_W-1:0]    ex_rd;
  logic                mem_memread;
  logic                mem_memwrite;
  logic                mem_regwrite;
  logic [REG_W-1:0]    mem_rd;
  logic                wb_regwrite;
  logic                wb_memtoreg;
  logic [REG_W-1:0]    wb_rd;
  logic [CNT_W-1:0]    retired;
`ifdef CTRL_JUMP_EN
  logic                ex_jump;
  logic                ex_jalr;
`endif

  // Datapath / pipeline side
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, freeze, flush_ex,
    input  hazard_stall, ex_alusrc, ex_aluop, ex_branch, ex_illegal, ex_rd,
           mem_memread, mem_memwrite, mem_regwrite, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd, retired
`ifdef CTRL_JUMP_EN
    , input ex_jump, ex_jalr
`endif
  );

  // Control unit side
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, freeze, flush_ex,
    output hazard_stall, ex_alusrc, ex_aluop, ex_branch, ex_illegal, ex_rd,
           mem_memread, mem_memwrite, mem_regwrite, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd, retired
`ifdef CTRL_JUMP_EN
    , output ex_jump, ex_jalr
`endif
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I opcode decoder: opcode -> control bundle plus the
// source-register usage flags needed by hazard detection.
// Optional feature macro: CTRL_JUMP_EN (JAL/JALR/LUI/AUIPC become legal).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic                     valid,
  input  logic [CTRL_OPCODE_W-1:0] opcode,
  input  logic [CTRL_REG_W-1:0]    rd,
  output ctrl_t                    ctrl,
  output logic                     uses_rs1,
  output logic                     uses_rs2
);

  // Opcode table; an invalid slot decodes to a bubble
  always_comb begin
    ctrl     = BUBBLE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (valid) begin
      ctrl.valid = 1'b1;
      ctrl.rd    = rd;
      case (opcode)
        OP_R: begin
          ctrl.aluop    = ALUOP_FUNCT;
          ctrl.regwrite = 1'b1;
          uses_rs1      = 1'b1;
          uses_rs2      = 1'b1;
        end
        OP_IALU: begin
          ctrl.alusrc   = 1'b1;
          ctrl.aluop    = ALUOP_FUNCT;
          ctrl.regwrite = 1'b1;
          uses_rs1      = 1'b1;
        end
        OP_BRANCH: begin
          ctrl.aluop  = ALUOP_BRANCH;
          ctrl.branch = 1'b1;
          uses_rs1    = 1'b1;
          uses_rs2    = 1'b1;
        end
        OP_LOAD: begin
          ctrl.alusrc   = 1'b1;
          ctrl.aluop    = ALUOP_ADD;
          ctrl.memread  = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 1'b1;
          uses_rs1      = 1'b1;
        end
        OP_STORE: begin
          ctrl.alusrc   = 1'b1;
          ctrl.aluop    = ALUOP_ADD;
          ctrl.memwrite = 1'b1;
          uses_rs1      = 1'b1;
          uses_rs2      = 1'b1;
        end
`ifdef CTRL_JUMP_EN
        OP_JAL: begin
          ctrl.jump     = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        OP_JALR: begin
          ctrl.jump     = 1'b1;
          ctrl.jalr     = 1'b1;
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          uses_rs1      = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          ctrl.alusrc   = 1'b1;
          ctrl.aluop    = ALUOP_ADD;
          ctrl.regwrite = 1'b1;
        end
`endif
        default: ctrl.illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded
      if (rd == '0) ctrl.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// Control unit for the 5-stage RV32I pipeline: decodes the ID instruction,
// carries its controls through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards, inserts bubbles on hazard or branch flush, honours a global freeze
// and counts retired instructions.
// Optional feature macro: CTRL_JUMP_EN (adds jump decode and ex_jump/ex_jalr).
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_ctrl_unit_if.slave  bus
);

  ctrl_t            id_ctrl;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;
  ctrl_t            id_ex_p0;
  mem_t             ex_mem_p1;
  wb_t              mem_wb_p2;
  logic [CNT_W-1:0] retired_q;

  ctrl_decode u_decode (
    .valid    (bus.id_valid),
    .opcode   (bus.id_opcode),
    .rd       (bus.id_rd),
    .ctrl     (id_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Load-use: the load in EX has not fetched its data yet, so a dependent
  // instruction in ID must wait one cycle
  always_comb begin
    hazard = bus.id_valid & id_ex_p0.memread & (id_ex_p0.rd != '0) &
             ((uses_rs1 & (id_ex_p0.rd == bus.id_rs1)) |
              (uses_rs2 & (id_ex_p0.rd == bus.id_rs2)));
  end

  // Stage registers and retire counter: reset > freeze > bubble > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_p0  <= BUBBLE;
      ex_mem_p1 <= to_mem(BUBBLE);
      mem_wb_p2 <= to_wb(to_mem(BUBBLE));
      retired_q <= '0;
    end else if (!bus.freeze) begin
      // ID -> EX
      id_ex_p0  <= (bus.flush_ex | hazard) ? BUBBLE : id_ctrl;
      // EX -> MEM
      ex_mem_p1 <= to_mem(id_ex_p0);
      // MEM -> WB
      mem_wb_p2 <= to_wb(ex_mem_p1);
      // WB -> retired
      if (mem_wb_p2.valid) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_alusrc    = id_ex_p0.alusrc;
  assign bus.ex_aluop     = id_ex_p0.aluop;
  assign bus.ex_branch    = id_ex_p0.branch;
  assign bus.ex_illegal   = id_ex_p0.illegal;
  assign bus.ex_rd        = id_ex_p0.rd;
  assign bus.mem_memread  = ex_mem_p1.memread;
  assign bus.mem_memwrite = ex_mem_p1.memwrite;
  assign bus.mem_regwrite = ex_mem_p1.regwrite;
  assign bus.mem_rd       = ex_mem_p1.rd;
  assign bus.wb_regwrite  = mem_wb_p2.regwrite;
  assign bus.wb_memtoreg  = mem_wb_p2.memtoreg;
  assign bus.wb_rd        = mem_wb_p2.rd;
  assign bus.retired      = retired_q;
`ifdef CTRL_JUMP_EN
  assign bus.ex_jump      = id_ex_p0.jump;
  assign bus.ex_jalr      = id_ex_p0.jalr;
`endif

endmodule
